// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory bundle; master = controller (drives o_*), slave = datapath/memories (drive i_*)
interface multicycle_ctrl_if;
  logic [31:0] i_instr;
  logic        o_imem_req;
  logic        i_imem_ready;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        i_dmem_ready;
  logic        i_br_equal;
  logic        i_br_less;
  logic        o_br_unsigned;
  logic        o_opa_sel;
  logic        o_opb_sel;
  logic [3:0]  o_alu_op;
  logic [1:0]  o_wb_sel;
  logic        o_rd_wren;
  logic        o_pc_en;
  logic        o_pc_sel;
  logic        o_ir_en;
  logic [2:0]  o_state;
  logic        o_illegal;
  modport master (
    input  i_instr, i_imem_ready, i_dmem_ready, i_br_equal, i_br_less,
    output o_imem_req, o_dmem_req, o_dmem_we, o_br_unsigned, o_opa_sel, o_opb_sel,
           o_alu_op, o_wb_sel, o_rd_wren, o_pc_en, o_pc_sel, o_ir_en, o_state, o_illegal
  );
  modport slave (
    output i_instr, i_imem_ready, i_dmem_ready, i_br_equal, i_br_less,
    input  o_imem_req, o_dmem_req, o_dmem_we, o_br_unsigned, o_opa_sel, o_opb_sel,
           o_alu_op, o_wb_sel, o_rd_wren, o_pc_en, o_pc_sel, o_ir_en, o_state, o_illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM; ports i_clk, i_reset (async high), bus (multicycle_ctrl_if.master: fetch/data handshakes, branch flags, datapath selects, state, trap)
module multicycle_ctrl (
  input logic               i_clk,
  input logic               i_reset,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state_q, state_d;
  // only the instruction fields the decoder consumes: {funct7[5], funct3, opcode}
  logic [10:0] ir_q, ir_d;
  logic [6:0] opc;
  logic [2:0] f3;
  logic f7b, is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, legal, taken, act;
  logic [3:0] alu_f;
  assign opc = ir_q[6:0];
  assign f3 = ir_q[9:7];
  assign f7b = ir_q[10];
  assign is_lui = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;
  assign is_br = opc == 7'b1100011;
  assign is_ld = opc == 7'b0000011;
  assign is_st = opc == 7'b0100011;
  assign is_opi = opc == 7'b0010011;
  assign is_op = opc == 7'b0110011;
  assign legal = (is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_opi | is_op) && !(is_br && f3[2:1] == 2'b01);
  // funct3[0] inverts the sense: BNE/BGE/BGEU
  assign taken = f3[2] ? bus.i_br_less ^ f3[0] : bus.i_br_equal ^ f3[0];
  assign alu_f = f3 == 3'd0 ? (is_op && f7b ? 4'd1 : 4'd0) :
                 f3 == 3'd1 ? 4'd2 : f3 == 3'd2 ? 4'd3 : f3 == 3'd3 ? 4'd4 :
                 f3 == 3'd4 ? 4'd5 : f3 == 3'd5 ? (f7b ? 4'd7 : 4'd6) :
                 f3 == 3'd6 ? 4'd8 : 4'd9;
  assign act = state_q == EXEC || state_q == MEM || state_q == WB;
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    bus.o_imem_req = 1'b0;
    bus.o_ir_en = 1'b0;
    bus.o_dmem_req = 1'b0;
    bus.o_dmem_we = 1'b0;
    bus.o_rd_wren = 1'b0;
    bus.o_pc_en = 1'b0;
    bus.o_pc_sel = 1'b0;
    bus.o_illegal = 1'b0;
    bus.o_state = state_q;
    bus.o_opa_sel = act & (is_auipc | is_jal | is_br);
    bus.o_opb_sel = act & !is_op;
    bus.o_alu_op = !act ? 4'd0 : is_lui ? 4'd10 : (is_op | is_opi) ? alu_f : 4'd0;
    bus.o_wb_sel = !act ? 2'd0 : is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : 2'd0;
    bus.o_br_unsigned = act & is_br & f3[2] & f3[1];
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        bus.o_imem_req = 1'b1;
        bus.o_ir_en = bus.i_imem_ready;
        if (bus.i_imem_ready) begin
          ir_d = {bus.i_instr[30], bus.i_instr[14:12], bus.i_instr[6:0]};
          state_d = DECODE;
        end
      end
      DECODE: state_d = legal ? EXEC : TRAP;
      EXEC: begin
        bus.o_pc_en = is_br;
        bus.o_pc_sel = is_br & taken;
        state_d = is_br ? FETCH : (is_ld | is_st) ? MEM : WB;
      end
      MEM: begin
        bus.o_dmem_req = 1'b1;
        bus.o_dmem_we = is_st;
        bus.o_pc_en = bus.i_dmem_ready & is_st;
        if (bus.i_dmem_ready) state_d = is_st ? FETCH : WB;
      end
      WB: begin
        bus.o_rd_wren = 1'b1;
        bus.o_pc_en = 1'b1;
        bus.o_pc_sel = is_jal | is_jalr;
        state_d = FETCH;
      end
      TRAP: bus.o_illegal = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; stimulus queues expected retire/trap snapshots, negedge monitor pops and compares
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {string name; logic [24:0] v;} exp_t;
  exp_t sb[$];
  exp_t e;
  int cyc, dcnt;
  logic [2:0] prev;
  bit trap_seen;
  logic [24:0] act;
  function automatic logic [24:0] mk(input int st, pe, rw, ps, oa, ob, alu, wb, bu, we, il, c, d);
    return {3'(st), 1'(pe), 1'(rw), 1'(ps), 1'(oa), 1'(ob), 4'(alu), 2'(wb), 1'(bu), 1'(we), 1'(il), 5'(c), 3'(d)};
  endfunction
  function automatic logic [18:0] allout();
    return {bus.o_imem_req, bus.o_dmem_req, bus.o_dmem_we, bus.o_br_unsigned, bus.o_opa_sel, bus.o_opb_sel,
            bus.o_alu_op, bus.o_wb_sel, bus.o_rd_wren, bus.o_pc_en, bus.o_pc_sel, bus.o_ir_en, bus.o_state, bus.o_illegal};
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0;
      dcnt = 0;
      prev = 3'd0;
      trap_seen = 1'b0;
    end else begin
      if (bus.o_state == 3'd1 && prev != 3'd1) begin
        cyc = 1;
        dcnt = 0;
      end else cyc++;
      if (bus.o_dmem_req) dcnt++;
      prev = bus.o_state;
      if (bus.o_pc_en || bus.o_rd_wren || (bus.o_state == 3'd6 && !trap_seen)) begin
        if (bus.o_state == 3'd6) trap_seen = 1'b1;
        act = {bus.o_state, bus.o_pc_en, bus.o_rd_wren, bus.o_pc_sel, bus.o_opa_sel, bus.o_opb_sel,
               bus.o_alu_op, bus.o_wb_sel, bus.o_br_unsigned, bus.o_dmem_we, bus.o_illegal, 5'(cyc), 3'(dcnt)};
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected event: got %h required none", act);
        end else begin
          e = sb.pop_front();
          check(e.name, 32'(act), 32'(e.v));
        end
      end
    end
  end
  task automatic run(input string name, input logic [31:0] ins, input int dly, input bit eq, input bit lt, input logic [24:0] ev);
    int k = 0;
    sb.push_back('{name, ev});
    bus.i_instr = ins;
    bus.i_br_equal = eq;
    bus.i_br_less = lt;
    bus.i_imem_ready = 1'b1;
    bus.i_dmem_ready = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_state == 3'd4) begin
        bus.i_dmem_ready = (k == dly);
        k++;
      end else bus.i_dmem_ready = 1'b0;
      if (bus.o_state == 3'd1 || bus.o_state == 3'd6) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s timeout: got state %0d required FETCH", name, bus.o_state);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_instr = '0;
    bus.i_imem_ready = 1'b0;
    bus.i_dmem_ready = 1'b0;
    bus.i_br_equal = 1'b0;
    bus.i_br_less = 1'b0;
    #1 rst = 1'b1;
    #11;
    check("reset outputs", 32'(allout()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("idle after reset", 32'(bus.o_state), 32'd0);
    @(posedge clk);
    #1;
    check("idle to fetch", 32'(bus.o_state), 32'd1);
    run("add", 32'h002081B3, 0, 0, 0, mk(5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0));
    run("sub", 32'h402081B3, 0, 0, 0, mk(5, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4, 0));
    run("auipc", 32'h00001297, 0, 0, 0, mk(5, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 4, 0));
    run("lui", 32'h123452B7, 0, 0, 0, mk(5, 1, 1, 0, 0, 1, 10, 0, 0, 0, 0, 4, 0));
    run("srai", 32'h4030D293, 0, 0, 0, mk(5, 1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 4, 0));
    run("sltiu", 32'h00513093, 0, 0, 0, mk(5, 1, 1, 0, 0, 1, 4, 0, 0, 0, 0, 4, 0));
    run("beq taken", 32'h00208463, 0, 1, 0, mk(3, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 3, 0));
    run("beq not taken", 32'h00208463, 0, 0, 0, mk(3, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3, 0));
    run("bltu taken", 32'h0020E463, 0, 0, 1, mk(3, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 3, 0));
    run("bgeu not taken", 32'h0020F463, 0, 0, 1, mk(3, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 3, 0));
    run("lw wait3", 32'h0000A283, 3, 0, 0, mk(5, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 8, 4));
    run("sw", 32'h0020A223, 0, 0, 0, mk(4, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 4, 1));
    run("jal", 32'h008000EF, 0, 0, 0, mk(5, 1, 1, 1, 1, 1, 0, 2, 0, 0, 0, 4, 0));
    run("jalr", 32'h000100E7, 0, 0, 0, mk(5, 1, 1, 1, 0, 1, 0, 2, 0, 0, 0, 4, 0));
    bus.i_instr = 32'h0020A223;
    bus.i_dmem_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.o_state == 3'd4) break;
    end
    check("sw reaches mem", 32'(bus.o_state), 32'd4);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b1;
    #1;
    check("async reset mid mem", 32'(allout()), 32'd0);
    @(posedge clk);
    #1;
    check("reset held", 32'(allout()), 32'd0);
    rst = 1'b0;
    check("idle after abort", 32'(bus.o_state), 32'd0);
    @(posedge clk);
    #1;
    check("fetch after abort", 32'(bus.o_state), 32'd1);
    run("trap ffffffff", 32'hFFFFFFFF, 0, 0, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("trap held", 32'({bus.o_illegal, bus.o_state, bus.o_pc_en, bus.o_rd_wren, bus.o_imem_req}), 32'b1_110_000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("fetch after trap reset", 32'(bus.o_state), 32'd1);
    run("trap branch f3=010", 32'h0020A463, 0, 0, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
